multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
//  Multi-cycle control FSM sequencing the processor datapath: fetch, decode, execute, memory, writeback.
//  Replaces single-cycle combinational decode; handshakes with instruction/data memory (req/ack).
//  Holds EXEC for multi-cycle mul. Flags illegal instructions and memory timeouts.
// PARAMETERS
//  MUL_CYCLES   3   cycles spent in EXEC for mul (>=1); all other ops take 1 EXEC cycle
//  MEM_TIMEOUT  15  cycles waiting for an ack before abandoning the access (>=1)
// PORTS
//  Clk        in   1  system clock, rising edge
//  Rst_n      in   1  asynchronous active-low reset
//  Opcode     in   6  instruction[31:26], valid from DECODE onward (IR registered)
//  Func       in   6  instruction[5:0]
//  Zero       in   1  ALU zero flag, sampled in EXEC
//  ImemAck    in   1  instruction memory ack; instruction valid to IR this cycle
//  DmemAck    in   1  data memory ack; lw data valid / sw done this cycle
//  ImemReq    out  1  instruction fetch request
//  IRWrite    out  1  load instruction register
//  PCWrite    out  1  PC <= PC+4, or branch target when PCSrc=1
//  PCSrc      out  1  select branch target
//  RegDst     out  1  1: rd, 0: rt
//  RegWrite   out  1  register file write strobe
//  ALUSrc     out  1  B operand = sign-extended immediate
//  ALUSrc2    out  1  A operand = shamt
//  RegSl      out  1  shift register select
//  ALUOp      out  4  ALU operation
//  MemRead    out  1  data memory read request
//  MemWrite   out  1  data memory write request
//  MemtoReg   out  1  writeback selects memory data
//  Busy       out  1  high in every state except FETCH
//  IllegalOp  out  1  one-cycle pulse on undecodable opcode/func
//  MemErr     out  1  one-cycle pulse on memory timeout
// BEHAVIOUR
//  Reset: state=FETCH, all outputs 0, counters 0. Asserting Rst_n low mid-instruction aborts it immediately; no write occurs.
//  States: FETCH, DECODE, EXEC, MEM, WB.
//  FETCH: ImemReq=1 until ImemAck. On ack: IRWrite=1, PCWrite=1 (PC+4), go to DECODE.
//   No ack within MEM_TIMEOUT cycles: MemErr pulse, counter reset, stay in FETCH and retry.
//  DECODE: classify opcode/func; illegal -> IllegalOp pulse, go to FETCH (no writes).
//  Decode table (ALUOp; RegDst/ALUSrc/ALUSrc2/RegSl):
//   op 000000: f100000 add 0000, f100010 sub 0001, f100100 and 0011, f100101 or 0100,
//    f101010 slt 0101, f000110 rotr 1010 (all RegDst=1); f000000 sll 1000, f000010 srl 1001 (RegDst=1, ALUSrc2=1, RegSl=1).
//   op 011100: f100001 clo 1011, f100000 clz 1100, f000010 mul 0010 (RegDst=1).
//   op 001000 addi 0000, op 001101 ori 0100, op 100011 lw 0000, op 101011 sw 0000 (ALUSrc=1, RegDst=0).
//   op 000101 bne 0111 (ALUSrc=0).
//  ALUOp/ALUSrc/ALUSrc2/RegSl/RegDst registered at DECODE exit, held until return to FETCH.
//  EXEC: mul stays MUL_CYCLES cycles (down-counter), others 1 cycle.
//   bne: PCWrite=PCSrc=(Zero==0) for one cycle, then FETCH. lw/sw: go to MEM. Others: go to WB.
//  MEM: MemRead (lw) or MemWrite (sw) held high until DmemAck, inclusive.
//   lw ack -> WB with MemtoReg=1. sw ack -> FETCH.
//   Timeout after MEM_TIMEOUT cycles: MemErr pulse, drop request, go to FETCH, no RegWrite.
//  WB: RegWrite=1 for exactly one cycle, then FETCH.
//  Ack arriving in the same cycle as a request is accepted (zero wait).
//  Acks outside FETCH/MEM are ignored.
//  Cycle counts at zero wait: R/imm 4 cycles (FETCH, DECODE, EXEC, WB), mul 3+MUL_CYCLES, lw 5, sw 4, bne 3.
// TESTING
//  add (op 0, f100000), acks immediate -> IRWrite@1, EXEC ALUOp=0000, RegWrite only in cycle 4, RegDst=1.
//  lw, DmemAck delayed 2 cycles -> MemRead high 3 cycles; WB RegWrite=1, MemtoReg=1; total 7 cycles.
//  bne with Zero=0 -> PCWrite=PCSrc=1 in EXEC; with Zero=1 -> PCSrc=0, no PCWrite in EXEC; RegWrite never asserted.
//  mul, MUL_CYCLES=3 -> EXEC held 3 cycles with ALUOp=0010, then WB; Busy high 5 cycles.
//  Opcode 111111 -> IllegalOp one-cycle pulse in DECODE, no RegWrite/MemWrite, back to FETCH.
//  sw with no DmemAck, MEM_TIMEOUT=15 -> MemWrite high 15 cycles, MemErr pulse, FETCH.
//  Rst_n low mid-MEM -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/multicycle_sequencer_if.sv
// Control/handshake bundle between the multi-cycle sequencer and its datapath.
// master: sequencer side; slave: datapath/memory side.
interface multicycle_sequencer_if;
    logic [5:0] Opcode;
    logic [5:0] Func;
    logic       Zero;
    logic       ImemAck;
    logic       DmemAck;
    logic       ImemReq;
    logic       IRWrite;
    logic       PCWrite;
    logic       PCSrc;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrc;
    logic       ALUSrc2;
    logic       RegSl;
    logic [3:0] ALUOp;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       Busy;
    logic       IllegalOp;
    logic       MemErr;

    modport master (
        input  Opcode, Func, Zero, ImemAck, DmemAck,
        output ImemReq, IRWrite, PCWrite, PCSrc, RegDst, RegWrite,
        output ALUSrc, ALUSrc2, RegSl, ALUOp,
        output MemRead, MemWrite, MemtoReg, Busy, IllegalOp, MemErr
    );

    modport slave (
        output Opcode, Func, Zero, ImemAck, DmemAck,
        input  ImemReq, IRWrite, PCWrite, PCSrc, RegDst, RegWrite,
        input  ALUSrc, ALUSrc2, RegSl, ALUOp,
        input  MemRead, MemWrite, MemtoReg, Busy, IllegalOp, MemErr
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: FETCH, DECODE, EXEC, MEM, WB with memory
// req/ack handshakes, multi-cycle mul, illegal-op and timeout flags.
module multicycle_sequencer #(
    parameter int MUL_CYCLES  = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input logic                   Clk,
    input logic                   Rst_n,
    multicycle_sequencer_if.master bus
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int MW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [TW-1:0] TLAST = TW'(MEM_TIMEOUT - 1);
    localparam logic [MW-1:0] MLAST = MW'(MUL_CYCLES - 1);

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB
    } state_t;

    typedef enum logic [2:0] {
        K_ALU, K_MUL, K_LW, K_SW, K_BNE
    } kind_t;

    state_t        state;
    kind_t         kind;
    logic [TW-1:0] wait_cnt;
    logic [MW-1:0] mul_cnt;
    logic [3:0]    alu_op;
    logic          reg_dst;
    logic          alu_src;
    logic          alu_src2;
    logic          reg_sl;

    logic          d_legal;
    kind_t         d_kind;
    logic [3:0]    d_alu;
    logic          d_dst;
    logic          d_src;
    logic          d_src2;
    logic          d_sl;

    logic op_r, op_s2, op_addi, op_ori, op_lw, op_sw, op_bne;

    assign op_r    = bus.Opcode == 6'b000000;
    assign op_s2   = bus.Opcode == 6'b011100;
    assign op_addi = bus.Opcode == 6'b001000;
    assign op_ori  = bus.Opcode == 6'b001101;
    assign op_lw   = bus.Opcode == 6'b100011;
    assign op_sw   = bus.Opcode == 6'b101011;
    assign op_bne  = bus.Opcode == 6'b000101;

    always_comb begin
        d_legal = 1'b1;
        d_kind  = K_ALU;
        d_alu   = 4'b0000;
        d_dst   = 1'b0;
        d_src   = 1'b0;
        d_src2  = 1'b0;
        d_sl    = 1'b0;
        unique case (1'b1)
            op_r: begin
                d_dst = 1'b1;
                unique case (bus.Func)
                    6'b100000: d_alu = 4'b0000;
                    6'b100010: d_alu = 4'b0001;
                    6'b100100: d_alu = 4'b0011;
                    6'b100101: d_alu = 4'b0100;
                    6'b101010: d_alu = 4'b0101;
                    6'b000110: d_alu = 4'b1010;
                    6'b000000: begin
                        d_alu  = 4'b1000;
                        d_src2 = 1'b1;
                        d_sl   = 1'b1;
                    end
                    6'b000010: begin
                        d_alu  = 4'b1001;
                        d_src2 = 1'b1;
                        d_sl   = 1'b1;
                    end
                    default: d_legal = 1'b0;
                endcase
            end
            op_s2: begin
                d_dst = 1'b1;
                unique case (bus.Func)
                    6'b100001: d_alu = 4'b1011;
                    6'b100000: d_alu = 4'b1100;
                    6'b000010: begin
                        d_alu  = 4'b0010;
                        d_kind = K_MUL;
                    end
                    default: d_legal = 1'b0;
                endcase
            end
            op_addi: d_src = 1'b1;
            op_ori: begin
                d_src = 1'b1;
                d_alu = 4'b0100;
            end
            op_lw: begin
                d_src  = 1'b1;
                d_kind = K_LW;
            end
            op_sw: begin
                d_src  = 1'b1;
                d_kind = K_SW;
            end
            op_bne: begin
                d_alu  = 4'b0111;
                d_kind = K_BNE;
            end
            default: d_legal = 1'b0;
        endcase
    end

    logic in_fetch, in_mem, in_wb;
    logic fetch_ack, imem_to, dmem_to;
    logic exec_done, bne_taken, back;

    assign in_fetch  = state == FETCH;
    assign in_mem    = state == MEM;
    assign in_wb     = state == WB;
    assign fetch_ack = in_fetch && bus.ImemAck;
    assign imem_to   = in_fetch && !bus.ImemAck && wait_cnt == TLAST;
    assign dmem_to   = in_mem && !bus.DmemAck && wait_cnt == TLAST;
    assign exec_done = state == EXEC && mul_cnt == '0;
    assign bne_taken = exec_done && kind == K_BNE && !bus.Zero;

    // Every path that ends the instruction early or normally returns here.
    assign back = (state == DECODE && !d_legal)
               || (exec_done && kind == K_BNE)
               || (in_mem && bus.DmemAck && kind == K_SW)
               || dmem_to
               || in_wb;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= FETCH;
            kind     <= K_ALU;
            wait_cnt <= '0;
            mul_cnt  <= '0;
            alu_op   <= 4'b0000;
            reg_dst  <= 1'b0;
            alu_src  <= 1'b0;
            alu_src2 <= 1'b0;
            reg_sl   <= 1'b0;
        end else if (back) begin
            state    <= FETCH;
            kind     <= K_ALU;
            wait_cnt <= '0;
            mul_cnt  <= '0;
            alu_op   <= 4'b0000;
            reg_dst  <= 1'b0;
            alu_src  <= 1'b0;
            alu_src2 <= 1'b0;
            reg_sl   <= 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (bus.ImemAck) begin
                        state    <= DECODE;
                        wait_cnt <= '0;
                    end else if (imem_to) begin
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                DECODE: begin
                    state    <= EXEC;
                    kind     <= d_kind;
                    alu_op   <= d_alu;
                    reg_dst  <= d_dst;
                    alu_src  <= d_src;
                    alu_src2 <= d_src2;
                    reg_sl   <= d_sl;
                    mul_cnt  <= (d_kind == K_MUL) ? MLAST : '0;
                end
                EXEC: begin
                    if (!exec_done)
                        mul_cnt <= mul_cnt - MW'(1);
                    else if (kind == K_LW || kind == K_SW)
                        state <= MEM;
                    else
                        state <= WB;
                end
                MEM: begin
                    if (bus.DmemAck) begin
                        state    <= WB;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    // Reset forces every output low, including the FETCH request.
    assign bus.ImemReq   = Rst_n & in_fetch;
    assign bus.IRWrite   = Rst_n & fetch_ack;
    assign bus.PCWrite   = Rst_n & (fetch_ack | bne_taken);
    assign bus.PCSrc     = Rst_n & bne_taken;
    assign bus.RegDst    = Rst_n & reg_dst;
    assign bus.RegWrite  = Rst_n & in_wb;
    assign bus.ALUSrc    = Rst_n & alu_src;
    assign bus.ALUSrc2   = Rst_n & alu_src2;
    assign bus.RegSl     = Rst_n & reg_sl;
    assign bus.ALUOp     = {4{Rst_n}} & alu_op;
    assign bus.MemRead   = Rst_n & in_mem & (kind == K_LW);
    assign bus.MemWrite  = Rst_n & in_mem & (kind == K_SW);
    assign bus.MemtoReg  = Rst_n & in_wb & (kind == K_LW);
    assign bus.Busy      = Rst_n & !in_fetch;
    assign bus.IllegalOp = Rst_n & (state == DECODE) & !d_legal;
    assign bus.MemErr    = Rst_n & (imem_to | dmem_to);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench: per-instruction expected control traces are queued
// with the ack pattern to drive, then popped and compared cycle by cycle.
module tb_multicycle_sequencer;

    typedef struct packed {
        logic       imem_req;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src;
        logic       alu_src2;
        logic       reg_sl;
        logic [3:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       busy;
        logic       illegal;
        logic       mem_err;
    } ctl_t;

    typedef struct {
        logic ia;
        logic da;
        ctl_t exp;
    } step_t;

    // kind: 0 alu, 1 mul, 2 lw, 3 sw, 4 bne, 5 illegal
    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic [3:0] alu;
        logic       dst;
        logic       src;
        logic       src2;
        logic       sl;
        int         kind;
    } ins_t;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    multicycle_sequencer_if bus ();

    multicycle_sequencer #(.MUL_CYCLES(3), .MEM_TIMEOUT(15)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;
    step_t q[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic ctl_t obs();
        ctl_t c;
        c = {bus.ImemReq, bus.IRWrite, bus.PCWrite, bus.PCSrc, bus.RegDst,
             bus.RegWrite, bus.ALUSrc, bus.ALUSrc2, bus.RegSl, bus.ALUOp,
             bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.Busy,
             bus.IllegalOp, bus.MemErr};
        return c;
    endfunction

    task automatic push(input ctl_t c, input logic ia, input logic da);
        step_t s;
        s.ia = ia;
        s.da = da;
        s.exp = c;
        q.push_back(s);
    endtask

    task automatic build(input ins_t in, input int idl, input int ddl,
                         input logic z, input logic nz);
        ctl_t c, f;
        int n;
        for (int k = 0; k <= idl; k++) begin
            c = '0;
            c.imem_req = 1'b1;
            if (k == idl) begin
                c.ir_write = 1'b1;
                c.pc_write = 1'b1;
            end else begin
                c.mem_err = (k % 15) == 14;
            end
            push(c, k == idl, 1'b0);
        end
        c = '0;
        c.busy = 1'b1;
        c.illegal = in.kind == 5;
        push(c, nz, nz);
        if (in.kind == 5) return;
        f = '0;
        f.busy = 1'b1;
        f.alu_op = in.alu;
        f.reg_dst = in.dst;
        f.alu_src = in.src;
        f.alu_src2 = in.src2;
        f.reg_sl = in.sl;
        n = (in.kind == 1) ? 3 : 1;
        for (int k = 0; k < n; k++) begin
            c = f;
            if (in.kind == 4 && !z) begin
                c.pc_write = 1'b1;
                c.pc_src = 1'b1;
            end
            push(c, nz, nz);
        end
        if (in.kind == 4) return;
        if (in.kind == 2 || in.kind == 3) begin
            if (ddl >= 15) begin
                for (int k = 0; k < 15; k++) begin
                    c = f;
                    c.mem_read = in.kind == 2;
                    c.mem_write = in.kind == 3;
                    c.mem_err = k == 14;
                    push(c, 1'b0, 1'b0);
                end
                return;
            end
            for (int k = 0; k <= ddl; k++) begin
                c = f;
                c.mem_read = in.kind == 2;
                c.mem_write = in.kind == 3;
                push(c, 1'b0, k == ddl);
            end
            if (in.kind == 3) return;
        end
        c = f;
        c.reg_write = 1'b1;
        c.mem_to_reg = in.kind == 2;
        push(c, nz, nz);
    endtask

    task automatic play(input string tag, input int limit);
        step_t s;
        int n = 0;
        while (q.size() > 0 && n < limit) begin
            s = q.pop_front();
            bus.ImemAck = s.ia;
            bus.DmemAck = s.da;
            @(negedge Clk);
            chk($sformatf("%s[%0d]", tag, n), 32'(obs()), 32'(s.exp));
            @(posedge Clk);
            #1;
            n++;
        end
        bus.ImemAck = 1'b0;
        bus.DmemAck = 1'b0;
    endtask

    task automatic run(input ins_t in, input int idl, input int ddl,
                       input logic z, input logic nz);
        bus.Opcode = in.op;
        bus.Func = in.fn;
        bus.Zero = z;
        build(in, idl, ddl, z, nz);
        play(in.name, 1000);
    endtask

    ins_t tab[$];
    ins_t i_add, i_mul, i_lw, i_sw, i_bne;

    initial begin
        tab.push_back('{"add",  6'b000000, 6'b100000, 4'b0000, 1, 0, 0, 0, 0});
        tab.push_back('{"sub",  6'b000000, 6'b100010, 4'b0001, 1, 0, 0, 0, 0});
        tab.push_back('{"and",  6'b000000, 6'b100100, 4'b0011, 1, 0, 0, 0, 0});
        tab.push_back('{"or",   6'b000000, 6'b100101, 4'b0100, 1, 0, 0, 0, 0});
        tab.push_back('{"slt",  6'b000000, 6'b101010, 4'b0101, 1, 0, 0, 0, 0});
        tab.push_back('{"rotr", 6'b000000, 6'b000110, 4'b1010, 1, 0, 0, 0, 0});
        tab.push_back('{"sll",  6'b000000, 6'b000000, 4'b1000, 1, 0, 1, 1, 0});
        tab.push_back('{"srl",  6'b000000, 6'b000010, 4'b1001, 1, 0, 1, 1, 0});
        tab.push_back('{"clo",  6'b011100, 6'b100001, 4'b1011, 1, 0, 0, 0, 0});
        tab.push_back('{"clz",  6'b011100, 6'b100000, 4'b1100, 1, 0, 0, 0, 0});
        tab.push_back('{"addi", 6'b001000, 6'b010101, 4'b0000, 0, 1, 0, 0, 0});
        tab.push_back('{"ori",  6'b001101, 6'b111111, 4'b0100, 0, 1, 0, 0, 0});
        tab.push_back('{"ill1", 6'b111111, 6'b100000, 4'b0000, 0, 0, 0, 0, 5});
        tab.push_back('{"ill2", 6'b000000, 6'b111111, 4'b0000, 0, 0, 0, 0, 5});
        tab.push_back('{"ill3", 6'b011100, 6'b000000, 4'b0000, 0, 0, 0, 0, 5});
        i_add = tab[0];
        i_mul = '{"mul", 6'b011100, 6'b000010, 4'b0010, 1, 0, 0, 0, 1};
        i_lw  = '{"lw",  6'b100011, 6'b000000, 4'b0000, 0, 1, 0, 0, 2};
        i_sw  = '{"sw",  6'b101011, 6'b000000, 4'b0000, 0, 1, 0, 0, 3};
        i_bne = '{"bne", 6'b000101, 6'b000000, 4'b0111, 0, 0, 0, 0, 4};

        bus.Opcode = 6'b000000;
        bus.Func = 6'b100000;
        bus.Zero = 1'b0;
        bus.ImemAck = 1'b1;
        bus.DmemAck = 1'b1;
        #2;
        chk("reset_outs", 32'(obs()), 32'h0);
        bus.ImemAck = 1'b0;
        bus.DmemAck = 1'b0;
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;

        run(i_add, 0, 0, 1'b0, 1'b0);
        foreach (tab[i]) run(tab[i], i % 3, 0, 1'b0, 1'b0);
        run(i_mul, 0, 0, 1'b0, 1'b0);
        run(i_lw, 0, 2, 1'b0, 1'b0);
        run(i_lw, 1, 0, 1'b0, 1'b0);
        run(i_sw, 0, 0, 1'b0, 1'b0);
        run(i_sw, 0, 99, 1'b0, 1'b0);
        run(i_lw, 0, 99, 1'b0, 1'b0);
        run(i_bne, 0, 0, 1'b0, 1'b0);
        run(i_bne, 0, 0, 1'b1, 1'b0);
        run(i_add, 17, 0, 1'b0, 1'b0);
        run(i_add, 0, 0, 1'b0, 1'b1);
        run(i_sw, 0, 14, 1'b0, 1'b0);

        // Abort a store in its third MEM cycle.
        bus.Opcode = i_sw.op;
        bus.Func = i_sw.fn;
        build(i_sw, 0, 99, 1'b0, 1'b0);
        play("sw_abort", 5);
        q.delete();
        #2;
        Rst_n = 1'b0;
        #1;
        chk("rst_mid_mem", 32'(obs()), 32'h0);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        run(i_mul, 0, 0, 1'b0, 1'b0);
        run(i_add, 0, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
